// File: rtl/intdiv_sched_if.sv
// Request/response bundle for intdiv_sched: two requester ports and one
// valid/ready response port. The master modport is the requester/consumer side,
// and the slave modport is the scheduler side.
interface intdiv_sched_if #(
  parameter int unsigned N = 5
) ();

  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_x;
  logic [N-1:0] req0_y;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_x;
  logic [N-1:0] req1_y;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_q;
  logic         rsp_id;
  logic         rsp_dz;

  modport master (
    output req0_valid, req0_x, req0_y,
    input  req0_ready,
    output req1_valid, req1_x, req1_y,
    input  req1_ready,
    input  rsp_valid, rsp_q, rsp_id, rsp_dz,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_x, req0_y,
    output req0_ready,
    input  req1_valid, req1_x, req1_y,
    output req1_ready,
    output rsp_valid, rsp_q, rsp_id, rsp_dz,
    input  rsp_ready
  );

endinterface

// File: rtl/intdiv_sched.sv
// intdiv_sched: round-robin scheduler for two requesters sharing one
// combinational signed array divider (intdiv_intdiv). Operands are registered,
// held for SETTLE_CYC cycles while the ripple array settles, and then the
// quotient is sampled. Divide-by-zero bypasses the core.
// Optional build macro INTDIV_SCHED_FASTPATH_EN: y == 1 returns x on the
// accept edge and skips the settle wait. Results are identical, and only the
// latency changes.

// Signed N-bit divider as a restoring array on magnitudes. The quotient is
// truncated toward zero. The result for y == 0 is meaningless because callers
// bypass that case.
module intdiv_intdiv #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] z
);

  logic [N-1:0] ax;
  logic [N-1:0] ay;
  logic [N-1:0] uq;
  logic [N-1:0] rem;
  logic [N:0]   trial;

  // One restoring subtract stage per quotient bit, MSB first.
  always_comb begin
    ax    = x[N-1] ? -x : x;
    ay    = y[N-1] ? -y : y;
    rem   = '0;
    uq    = '0;
    trial = '0;
    for (int i = N - 1; i >= 0; i--) begin
      trial = {rem, ax[i]};
      if (trial >= {1'b0, ay}) begin
        trial = trial - {1'b0, ay};
        uq[i] = 1'b1;
      end
      rem = trial[N-1:0];
    end
    z = (x[N-1] ^ y[N-1]) ? -uq : uq;
  end

endmodule

module intdiv_sched #(
  parameter int unsigned N          = 5,
  // Legal range 1..15; the settle counter is 4 bits wide.
  parameter int unsigned SETTLE_CYC = 3
) (
  input logic          clk,
  input logic          rst_n,
  intdiv_sched_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

  localparam logic [3:0]   CntLoad = 4'(SETTLE_CYC - 1);
  localparam logic [N-1:0] One     = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] x_q, x_d;
  logic [N-1:0] y_q, y_d;
  logic [N-1:0] quo_q, quo_d;
  logic         id_q, id_d;
  logic         dz_q, dz_d;
  logic         last_q, last_d;
  logic [3:0]   cnt_q, cnt_d;

  logic         gnt0;
  logic         gnt1;
  logic [N-1:0] acc_x;
  logic [N-1:0] acc_y;
  logic [N-1:0] core_z;

  // The core only ever sees registered operands, so it is stable across SETTLE.
  intdiv_intdiv #(
    .N (N)
  ) u_core (
    .x (x_q),
    .y (y_q),
    .z (core_z)
  );

  // Round-robin grant: on contention the requester that did not win last time wins.
  always_comb begin
    gnt0  = (state_q == StIdle) && bus.req0_valid && (!bus.req1_valid || last_q);
    gnt1  = (state_q == StIdle) && bus.req1_valid && (!bus.req0_valid || !last_q);
    acc_x = gnt1 ? bus.req1_x : bus.req0_x;
    acc_y = gnt1 ? bus.req1_y : bus.req0_y;
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp_valid  = (state_q == StDone);
  assign bus.rsp_q      = quo_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_dz     = dz_q;

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    quo_d   = quo_q;
    id_d    = id_q;
    dz_d    = dz_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (gnt0 || gnt1) begin
          x_d    = acc_x;
          y_d    = acc_y;
          id_d   = gnt1;
          last_d = gnt1;
          if (acc_y == '0) begin
            quo_d   = '0;
            dz_d    = 1'b1;
            state_d = StDone;
          end
`ifdef INTDIV_SCHED_FASTPATH_EN
          else if (acc_y == One) begin
            quo_d   = acc_x;
            dz_d    = 1'b0;
            state_d = StDone;
          end
`endif
          else begin
            cnt_d   = CntLoad;
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          quo_d   = core_z;
          dz_d    = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      quo_q   <= '0;
      id_q    <= 1'b0;
      dz_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      quo_q   <= quo_d;
      id_q    <= id_d;
      dz_q    <= dz_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_intdiv_sched.sv
// Self-checking bench for intdiv_sched. A negedge monitor scoreboards every
// accepted operation against a reference divide model. It also checks the
// response fields and the latency, which is counted in edges and includes the
// accept edge.
module tb_intdiv_sched;

  localparam int unsigned N          = 5;
  localparam int unsigned SETTLE_CYC = 3;

  typedef struct {
    logic [N-1:0] q;
    logic         id;
    logic         dz;
    int           lat;
    int           acc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exp_t sb[$];
  int   n_tests    = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  logic prev_valid = 1'b0;
  int   w;

  always #5 clk = ~clk;

  intdiv_sched_if #(.N(N)) bus ();

  intdiv_sched #(
    .N          (N),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model_q(input logic [N-1:0] x, input logic [N-1:0] y);
    int xi;
    int yi;
    int qi;
    if (y == '0) return '0;
    xi = $signed(x);
    yi = $signed(y);
    qi = xi / yi;
    return qi[N-1:0];
  endfunction

  function automatic int model_lat(input logic [N-1:0] y);
    if (y == '0) return 1;
`ifdef INTDIV_SCHED_FASTPATH_EN
    if (y == 1) return 1;
`endif
    return SETTLE_CYC + 1;
  endfunction

  // Monitor: ready exclusivity, accepts to scoreboard, responses from scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.req0_ready | bus.req1_ready)
        check("rdy_excl", 32'(bus.req0_ready & bus.req1_ready), 0);
      if (bus.rsp_valid && !prev_valid) begin
        if (sb.size() == 0) check("rsp_unexpected", 32'(bus.rsp_valid), 0);
        else check("latency", cyc - sb[0].acc, sb[0].lat);
      end
      if (bus.rsp_valid && bus.rsp_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check("rsp_q", 32'(bus.rsp_q), 32'(e.q));
        check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        check("rsp_dz", 32'(bus.rsp_dz), 32'(e.dz));
      end
      if (bus.req0_valid && bus.req0_ready) begin
        e = '{q: model_q(bus.req0_x, bus.req0_y), id: 1'b0, dz: (bus.req0_y == '0),
              lat: model_lat(bus.req0_y), acc: cyc};
        sb.push_back(e);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        e = '{q: model_q(bus.req1_x, bus.req1_y), id: 1'b1, dz: (bus.req1_y == '0),
              lat: model_lat(bus.req1_y), acc: cyc};
        sb.push_back(e);
      end
    end
    prev_valid = bus.rsp_valid;
  end

  task automatic issue(input bit k, input logic [N-1:0] x, input logic [N-1:0] y,
                       output int waits);
    bit ok;
    ok    = 1'b0;
    waits = 0;
    @(posedge clk); #1;
    if (k) begin
      bus.req1_x = x; bus.req1_y = y; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_x = x; bus.req0_y = y; bus.req0_valid = 1'b1;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (k ? bus.req1_ready : bus.req0_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) check("accept_timeout", waits, 0);
    @(posedge clk); #1;
    if (k) bus.req1_valid = 1'b0;
    else bus.req0_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", sb.size(), 0);
  endtask

  // Both requesters are already valid; collect n grants and check they alternate.
  task automatic contend(input int n, input bit first);
    bit exp_id;
    int got;
    exp_id = first;
    got    = 0;
    for (int i = 0; i < 100 * n && got < n; i++) begin
      @(negedge clk);
      if (bus.req0_ready | bus.req1_ready) begin
        check("grant_order", 32'(bus.req1_ready), 32'(exp_id));
        exp_id = ~exp_id;
        got++;
      end
    end
    check("contend_grants", got, n);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0;
    bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0;
    bus.rsp_ready  = 1'b1;

    // Reset state
    #12;
    check("rst_valid", 32'(bus.rsp_valid), 0);
    check("rst_q", 32'(bus.rsp_q), 0);
    check("rst_id", 32'(bus.rsp_id), 0);
    check("rst_dz", 32'(bus.rsp_dz), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single request: 7/3 -> 2, accepted in the first cycle
    issue(1'b0, 5'd7, 5'd3, w);
    check("t1_first_rdy", w, 0);
    drain();

    // Divide by zero on req1, then a normal req1 op (leaves last = 1)
    issue(1'b1, 5'd9, 5'd0, w);
    drain();
    issue(1'b1, 5'd12, 5'd3, w);
    drain();

    // Contention: grants 0,1,0,1 with q 2/id0 and q 4/id1
    @(posedge clk); #1;
    bus.req0_x = 5'd14; bus.req0_y = 5'd5; bus.req0_valid = 1'b1;
    bus.req1_x = 5'd12; bus.req1_y = 5'd3; bus.req1_valid = 1'b1;
    contend(4, 1'b0);
    drain();

    // Backpressure: 13/4 -> 3 held for 10 cycles with req0 still valid
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req0_x = 5'd13; bus.req0_y = 5'd4; bus.req0_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("bp_rsp_timeout", 32'(bus.rsp_valid), 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", 32'(bus.rsp_valid), 1);
      check("bp_q", 32'(bus.rsp_q), 3);
      check("bp_id", 32'(bus.rsp_id), 0);
      check("bp_dz", 32'(bus.rsp_dz), 0);
      check("bp_no_rdy", 32'(bus.req0_ready), 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_rdy", 32'(bus.req0_ready), 0);
    @(negedge clk);
    check("bp_next_accept", 32'(bus.req0_ready), 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    drain();

    // Reset during SETTLE of 8/2: outputs clear at once, no response appears
    issue(1'b0, 5'd8, 5'd2, w);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("mrst_valid", 32'(bus.rsp_valid), 0);
    check("mrst_q", 32'(bus.rsp_q), 0);
    check("mrst_id", 32'(bus.rsp_id), 0);
    check("mrst_dz", 32'(bus.rsp_dz), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mrst_no_rsp", 32'(bus.rsp_valid), 0);
    end
    // After reset req0 wins: -9/2 -> -4, 15/-4 -> -3
    @(posedge clk); #1;
    bus.req0_x = 5'b10111; bus.req0_y = 5'd2;    bus.req0_valid = 1'b1;
    bus.req1_x = 5'd15;    bus.req1_y = 5'b11100; bus.req1_valid = 1'b1;
    contend(2, 1'b0);
    drain();

    // Divide by one (fast path when enabled), then the overflow case -16/-1
    issue(1'b1, 5'd11, 5'd1, w);
    drain();
    issue(1'b0, 5'b10000, 5'b11111, w);
    drain();

    // Random operations, including some divisors of zero and one
    for (int i = 0; i < 16; i++) begin
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), w);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
